ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-master arbiter sharing the single-port data syncram between the cpu32 data port (master 0) and a secondary requester such as a loader or DMA engine (master 1). Master 0 has priority. Master 1 has a bounded wait and can lock the RAM for read-modify-write sequences. The block sits between the masters and the RAM. Read data is returned one cycle after grant, with a per-master valid.

## Interface
- AW, 8: RAM word-address width.
- DW, 32: data width.
- STARVE, 4: maximum consecutive m0 grants while m1 is pending, before m1 is forced. Legal range is 1..15.

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  AW  master 0 word address
- m0_wdata  in  DW  master 0 write data
- m0_gnt  out  1  master 0 access accepted this cycle
- m0_rdata  out  DW  master 0 read data
- m0_rvalid  out  1  m0_rdata valid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as m0, for master 1
- m1_lock  in  1  hold the RAM for master 1 after this access
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DW  RAM read data, valid the cycle after the address

## Operation
- State registers:
  - cnt: 4 bits, starvation counter.
  - locked: 1 bit.
  - rtag: 2 bits, one-hot pending-read owner.
  - All are cleared asynchronously when reset_n=0.
- Grant logic is combinational from the req inputs and the state registers. At most one gnt is high per cycle. Both gnts are 0 while reset_n=0.
- Grant priority, first match wins:
  1. locked && m1_req: grant m1.
  2. m1_req && cnt==STARVE: grant m1.
  3. m0_req: grant m0.
  4. m1_req: grant m1.
  5. Otherwise: no grant.
- Mux:
  - ram_addr, ram_wdata and ram_we come from the winner.
  - ram_we = winner_we && gnt.
  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- cnt update at the clock edge:
  - m1 granted, or m1_req=0: clear cnt to 0.
  - m0 granted while m1_req=1: increment cnt, saturating at STARVE.
  - Otherwise: hold.
- locked update at the clock edge:
  - Set when m1 is granted with m1_lock=1.
  - Clear when m1 is granted with m1_lock=0, or when m1_req=0.
  - While locked=1 and m1_req=0, m0 may be granted in that cycle.
- Reads:
  - A granted read (we=0) sets rtag to the winner at the edge. rtag is 0 after a write or idle cycle.
  - mN_rvalid = rtag[N].
  - mN_rdata = ram_rdata when rtag[N]=1, else 0.
- Writes produce no response. A write completes at the grant edge.
- Requester rules:
  - A requester holds req, we, addr and wdata stable until it samples gnt=1 at a clock edge.
  - Dropping req before a grant withdraws the request, with no side effects.

## Timing
- Grant is issued in the same cycle as the request. Zero added latency when uncontested.
- Read latency is 1 cycle: rvalid and rdata are valid in the cycle after the gnt cycle.
- Back-to-back accesses are sustained at one per cycle, and can be of mixed masters. A write followed by a read of the same address in the next cycle returns the new data.
- Starvation bound: an unlocked, continuously requesting m1 is granted within STARVE+1 cycles.
- Reset values of outputs:
  - All gnt, rvalid and ram_we are 0.
  - All rdata, ram_addr and ram_wdata are 0.
- Reset asserted mid-read: rvalid drops immediately (asynchronously). After reset release, no stale rvalid appears.
- Starvation does not break a lock. While locked, m0 waits with no bound; the m1 agent is responsible for bounding lock length.

## Test plan
- Reset: hold reset_n=0 with both reqs high -> every output is 0 and ram_we=0. Release -> m0_gnt=1 in the first cycle.
- m0 write then read: m0 writes addr 0x10, data 0x12345678, then reads 0x10 in the next cycle -> m0_gnt=1 in both cycles. m0_rvalid=1 with m0_rdata=0x12345678 one cycle after the read. m1_rvalid stays 0 throughout.
- Starvation, STARVE=4: both reqs high continuously, reads only -> grant pattern m0,m0,m0,m0,m1 repeating. Each m1 grant is followed by m1_rvalid the next cycle.
- Lock: m1 performs 3 accesses with m1_lock=1,1,0 while m0_req is held high -> m0_gnt=0 for those 3 cycles, then m0_gnt=1. A write by m1 to 0x20 (0xCAFEF00D) inside the lock is read back by m0 as 0xCAFEF00D.
- Routing and reset: m1 reads 0x05 (preloaded 0xA5A5A5A5), then m0 reads 0x06 (preloaded 0x5A5A5A5A) -> m1_rvalid then m0_rvalid in consecutive cycles, each with the correct data. Repeat with reset_n pulsed low mid-cycle after the m1 grant -> m1_rvalid=0 immediately, cnt and locked cleared, and no rvalid after release.
- Withdraw: m1_req raised for 2 cycles while m0 is granted, then dropped -> no m1_gnt, cnt returns to 0, and the next m1 request waits the full STARVE again.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data syncram. Master 0 has priority.
// Master 1 has a bounded wait and can lock the RAM. Read data returns one cycle after grant.
module ram_arbiter #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 32,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_t;

  localparam logic [3:0] STARVE_C = 4'(STARVE);

  logic [3:0] cnt;
  logic       locked;
  logic [1:0] rtag;
  sel_t       sel;

  // Lock and starvation both outrank m0; reset forces no grant.
  always_comb begin
    sel = SEL_NONE;
    if (!reset_n)
      sel = SEL_NONE;
    else if (m1_req && (locked || cnt == STARVE_C))
      sel = SEL_M1;
    else if (m0_req)
      sel = SEL_M0;
    else if (m1_req)
      sel = SEL_M1;
  end

  assign m0_gnt = (sel == SEL_M0);
  assign m1_gnt = (sel == SEL_M1);

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (sel)
      SEL_M0: begin
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        ram_we    = m0_we;
      end
      SEL_M1: begin
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
        ram_we    = m1_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      locked <= 1'b0;
      rtag   <= '0;
    end else begin
      if (m1_gnt || !m1_req)
        cnt <= '0;
      else if (m0_gnt && cnt != STARVE_C)
        cnt <= cnt + 4'd1;

      if (m1_gnt)
        locked <= m1_lock;
      else if (!m1_req)
        locked <= 1'b0;

      rtag <= {m1_gnt && !m1_we, m0_gnt && !m0_we};
    end
  end

  assign m0_rvalid = rtag[0];
  assign m1_rvalid = rtag[1];
  assign m0_rdata  = rtag[0] ? ram_rdata : '0;
  assign m1_rdata  = rtag[1] ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural syncram attached to the RAM port.
module tb_ram_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned STARVE = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;
  logic [DW-1:0] mem [0:255];

  int compared = 0;
  int mismatched = 0;

  ram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic test_reset();
    reset_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h33; m0_wdata = 32'h11111111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h44; m1_wdata = 32'h22222222; m1_lock = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b00) begin mismatched++; $display("FAIL reset_gnt got=%b want=00", {m0_gnt, m1_gnt}); end
    compared++; if (ram_we !== 1'b0) begin mismatched++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
    compared++; if (ram_addr !== '0 || ram_wdata !== '0) begin mismatched++; $display("FAIL reset_ram_bus got=%h/%h want=0/0", ram_addr, ram_wdata); end
    compared++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin mismatched++; $display("FAIL reset_rvalid got=%b want=00", {m0_rvalid, m1_rvalid}); end
    compared++; if (m0_rdata !== '0 || m1_rdata !== '0) begin mismatched++; $display("FAIL reset_rdata got=%h/%h want=0/0", m0_rdata, m1_rdata); end
    @(negedge clk);
    reset_n = 1'b1; m0_we = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("FAIL release_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    compared++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin mismatched++; $display("FAIL release_read got=%b/%h want=1/0", m0_rvalid, m0_rdata); end
    @(negedge clk);
  endtask

  task automatic test_m0_write_read();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 32'h12345678;
    #1;
    compared++; if (m0_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h10) begin mismatched++; $display("FAIL m0_write got gnt=%b we=%b addr=%h want 1/1/10", m0_gnt, ram_we, ram_addr); end
    @(negedge clk);
    m0_we = 1'b0;
    #1;
    compared++; if (m0_gnt !== 1'b1 || ram_we !== 1'b0) begin mismatched++; $display("FAIL m0_read_gnt got gnt=%b we=%b want 1/0", m0_gnt, ram_we); end
    compared++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin mismatched++; $display("FAIL m0_write_norsp got=%b%b want=00", m0_rvalid, m1_rvalid); end
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    compared++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin mismatched++; $display("FAIL m0_readback got=%b/%h want=1/12345678", m0_rvalid, m0_rdata); end
    compared++; if (m1_rvalid !== 1'b0) begin mismatched++; $display("FAIL m0_readback_m1v got=%b want=0", m1_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    logic exp1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h06;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h05; m1_lock = 1'b0;
      #1;
      exp1 = (i % 5 == 4);
      compared++; if (m1_gnt !== exp1 || m0_gnt !== !exp1) begin mismatched++; $display("FAIL starve_gnt[%0d] got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, !exp1, exp1); end
      compared++; if (m0_rvalid !== prev0 || m1_rvalid !== prev1) begin mismatched++; $display("FAIL starve_rvalid[%0d] got=%b%b want=%b%b", i, m0_rvalid, m1_rvalid, prev0, prev1); end
      if (prev1) begin
        compared++; if (m1_rdata !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL starve_m1_rdata[%0d] got=%h want=a5a5a5a5", i, m1_rdata); end
      end
      if (prev0) begin
        compared++; if (m0_rdata !== 32'h5A5A5A5A) begin mismatched++; $display("FAIL starve_m0_rdata[%0d] got=%h want=5a5a5a5a", i, m0_rdata); end
      end
      prev0 = !exp1;
      prev1 = exp1;
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    compared++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL starve_last got=%b/%h want=1/a5a5a5a5", m1_rvalid, m1_rdata); end
    @(negedge clk);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h05; m1_lock = 1'b1;
      #1;
      compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("FAIL lock_pre[%0d] got=%b want=10", i, {m0_gnt, m1_gnt}); end
    end
    @(negedge clk);
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b01) begin mismatched++; $display("FAIL lock_acc0 got=%b want=01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 32'hCAFEF00D; m1_lock = 1'b1;
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b01 || ram_we !== 1'b1) begin mismatched++; $display("FAIL lock_acc1 got=%b we=%b want=01 we=1", {m0_gnt, m1_gnt}, ram_we); end
    compared++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL lock_rd0 got=%b/%h want=1/a5a5a5a5", m1_rvalid, m1_rdata); end
    @(negedge clk);
    m1_we = 1'b0; m1_addr = 8'h06; m1_lock = 1'b0;
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b01) begin mismatched++; $display("FAIL lock_acc2 got=%b want=01", {m0_gnt, m1_gnt}); end
    compared++; if (m1_rvalid !== 1'b0) begin mismatched++; $display("FAIL lock_wr_norsp got=%b want=0", m1_rvalid); end
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("FAIL lock_release got=%b want=10", {m0_gnt, m1_gnt}); end
    compared++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5A5A5A5A) begin mismatched++; $display("FAIL lock_rd2 got=%b/%h want=1/5a5a5a5a", m1_rvalid, m1_rdata); end
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    compared++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hCAFEF00D) begin mismatched++; $display("FAIL lock_m0_readback got=%b/%h want=1/cafef00d", m0_rvalid, m0_rdata); end
    @(negedge clk);
  endtask

  task automatic test_routing_reset();
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h05; m1_lock = 1'b0; m0_req = 1'b0;
    #1;
    compared++; if ({m0_gnt, m1_gnt} !== 2'b01) begin mismatched++; $display("FAIL route_m1_gnt got=%b want=01", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h06;
    #1;
    compared++; if (m0_gnt !== 1'b1) begin mismatched++; $display("FAIL route_m0_gnt got=%b want=1", m0_gnt); end
    compared++; if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hA5A5A5A5 || m0_rdata !== '0) begin mismatched++; $display("FAIL route_m1_rsp got=%b%b m1=%h m0=%h want=01 a5a5a5a5 0", m0_rvalid, m1_rvalid, m1_rdata, m0_rdata); end
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    compared++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h5A5A5A5A || m1_rdata !== '0) begin mismatched++; $display("FAIL route_m0_rsp got=%b%b m0=%h m1=%h want=10 5a5a5a5a 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata); end
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 8'h05; m1_lock = 1'b1;
    #1;
    compared++; if (m1_gnt !== 1'b1) begin mismatched++; $display("FAIL route2_m1_gnt got=%b want=1", m1_gnt); end
    @(posedge clk);
    #2;
    compared++; if (m1_rvalid !== 1'b1 || dut.locked !== 1'b1) begin mismatched++; $display("FAIL route2_pre got rvalid=%b locked=%b want 1/1", m1_rvalid, dut.locked); end
    reset_n = 1'b0;
    #1;
    compared++; if (m1_rvalid !== 1'b0 || m1_rdata !== '0) begin mismatched++; $display("FAIL route2_async got=%b/%h want=0/0", m1_rvalid, m1_rdata); end
    compared++; if (dut.locked !== 1'b0 || dut.cnt !== 4'd0 || m1_gnt !== 1'b0) begin mismatched++; $display("FAIL route2_state got locked=%b cnt=%0d gnt=%b want 0/0/0", dut.locked, dut.cnt, m1_gnt); end
    m1_req = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    compared++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin mismatched++; $display("FAIL route2_stale got=%b want=00", {m0_rvalid, m1_rvalid}); end
  endtask

  task automatic test_withdraw();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h06;
      m1_req = (i < 2); m1_we = 1'b0; m1_addr = 8'h05; m1_lock = 1'b0;
      #1;
      compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("FAIL withdraw_gnt[%0d] got=%b want=10", i, {m0_gnt, m1_gnt}); end
      if (i == 2) begin
        compared++; if (dut.cnt !== 4'd2) begin mismatched++; $display("FAIL withdraw_cnt2 got=%0d want=2", dut.cnt); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m1_req = 1'b1;
      #1;
      if (i == 0) begin
        compared++; if (dut.cnt !== 4'd0) begin mismatched++; $display("FAIL withdraw_cnt0 got=%0d want=0", dut.cnt); end
      end
      compared++; if (m1_gnt !== (i == 4) || m0_gnt !== (i != 4)) begin mismatched++; $display("FAIL rewait_gnt[%0d] got m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, i != 4, i == 4); end
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    compared++; if (dut.cnt !== 4'd2 || m0_rvalid !== 1'b1) begin mismatched++; $display("FAIL midreset_pre got cnt=%0d rvalid=%b want 2/1", dut.cnt, m0_rvalid); end
    reset_n = 1'b0;
    #1;
    compared++; if (dut.cnt !== 4'd0 || m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin mismatched++; $display("FAIL midreset got cnt=%0d rvalid=%b gnt=%b want 0/0/0", dut.cnt, m0_rvalid, m0_gnt); end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    compared++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin mismatched++; $display("FAIL midreset_stale got=%b want=00", {m0_rvalid, m1_rvalid}); end
  endtask

  initial begin
    for (int unsigned a = 0; a < 256; a++) mem[a] = '0;
    mem[5] = 32'hA5A5A5A5;
    mem[6] = 32'h5A5A5A5A;
    test_reset();
    test_m0_write_read();
    test_starvation();
    test_lock();
    test_routing_reset();
    test_withdraw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
